spi_master_16bit: RTL and testbench



---
 rtl/spi_master_16bit.sv | 175 +++++++++++++++++
 tb/tb_spi_master_16bit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_16bit.sv
// SPI mode-3 master for the ADXL345 controller: one 16-bit chip-select frame per
// accepted start, MSB first. MOSI changes on SCLK falling edges and MISO is sampled
// on SCLK rising edges. All outputs come straight from flops.
module spi_master_16bit #(
    parameter int unsigned CLK_DIV  = 10,  // clk cycles per SCLK half-period (>= 2)
    parameter int unsigned CS_SETUP = 2,   // cs_n fall to SCLK activity (>= 1)
    parameter int unsigned CS_HOLD  = 2,   // last SCLK rise to cs_n rise (>= 1)
    parameter int unsigned CS_GAP   = 4    // cs_n high before busy drops (>= 1)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] data_in_16bit,
    output logic        busy,
    output logic [15:0] data_out_16bit,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso
);

    localparam int unsigned CntW = 16;

    // Terminal counts for the shared phase/divider counter.
    localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
    localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD - 1);
    localparam logic [CntW-1:0] GapLast   = CntW'(CS_GAP - 1);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    // 32 SCLK toggles per frame; the last one (index 31) is the 16th rising edge.
    localparam logic [5:0] LastToggle = 6'd31;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXfer,
        StHold,
        StGap
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0] cnt_q, cnt_d;      // phase length in SETUP/HOLD/GAP, divider in XFER
    logic [5:0]      tog_q, tog_d;      // SCLK toggles already made this frame
    logic [15:0]     tx_sr_q, tx_sr_d;
    logic [15:0]     rx_sr_q, rx_sr_d;
    logic [15:0]     dout_q, dout_d;
    logic            busy_q, busy_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;

    // State and output registers; reset returns the bus to its idle levels at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tog_q   <= '0;
            tx_sr_q <= '0;
            rx_sr_q <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tog_q   <= tog_d;
            tx_sr_q <= tx_sr_d;
            rx_sr_q <= rx_sr_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    // Next-state logic: frame sequencing, SCLK generation and both shift registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tog_d   = tog_q;
        tx_sr_d = tx_sr_q;
        rx_sr_d = rx_sr_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;

        case (state_q)
            StIdle: begin
                // Level-sensitive: a start held high re-triggers right after GAP.
                if (start) begin
                    tx_sr_d = data_in_16bit;
                    mosi_d  = data_in_16bit[15];
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end

            StSetup: begin
                if (cnt_q == SetupLast) begin
                    cnt_d   = '0;
                    tog_d   = '0;
                    state_d = StXfer;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StXfer: begin
                if (cnt_q == DivLast) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    tog_d  = tog_q + 6'd1;
                    if (sclk_q) begin
                        // Falling edge. Bit 15 was already driven at acceptance,
                        // so the first fall leaves MOSI alone.
                        if (tog_q != 6'd0) begin
                            tx_sr_d = {tx_sr_q[14:0], 1'b0};
                            mosi_d  = tx_sr_q[14];
                        end
                    end else begin
                        // Rising edge: capture MISO in the cycle SCLK goes high.
                        rx_sr_d = {rx_sr_q[14:0], miso};
                        if (tog_q == LastToggle) begin
                            state_d = StHold;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StHold: begin
                if (cnt_q == HoldLast) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    dout_d  = rx_sr_q;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy           = busy_q;
    assign data_out_16bit = dout_q;
    assign cs_n           = cs_n_q;
    assign sclk           = sclk_q;
    assign mosi           = mosi_q;

endmodule

// File: tb/tb_spi_master_16bit.sv
// Self-checking bench for spi_master_16bit with a behavioural ADXL345-side model:
// MISO shifts a chosen word out on SCLK falls, MOSI is captured on SCLK rises.
module tb_spi_master_16bit;

    localparam int unsigned ClkDiv   = 10;
    localparam int unsigned CsSetup  = 2;
    localparam int unsigned CsHold   = 2;
    localparam int unsigned CsGap    = 4;
    localparam int unsigned BusyLen  = CsSetup + 32 * ClkDiv + CsHold + CsGap;
    localparam int unsigned CsLowLen = BusyLen - CsGap;
    localparam int unsigned Budget   = 2 * BusyLen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in_16bit = '0;
    logic        miso = 1'b0;
    logic        busy;
    logic [15:0] data_out_16bit;
    logic        cs_n;
    logic        sclk;
    logic        mosi;

    spi_master_16bit #(
        .CLK_DIV  (ClkDiv),
        .CS_SETUP (CsSetup),
        .CS_HOLD  (CsHold),
        .CS_GAP   (CsGap)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .data_in_16bit  (data_in_16bit),
        .busy           (busy),
        .data_out_16bit (data_out_16bit),
        .cs_n           (cs_n),
        .sclk           (sclk),
        .mosi           (mosi),
        .miso           (miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bus monitor and device model; counters only ever grow, tests work on deltas.
    logic        prev_sclk = 1'b1;
    logic [15:0] prev_dout = '0;
    logic [15:0] mosi_cap = '0;
    logic [15:0] miso_word = '0;
    int rise_cnt = 0, fall_cnt = 0, busy_cyc = 0, cs_low_cyc = 0;
    int cs_edges = 0, dout_moves = 0, miso_idx = 0;

    always @(posedge clk) begin
        #2;
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            rise_cnt++;
            mosi_cap = {mosi_cap[14:0], mosi};
        end
        if (sclk === 1'b0 && prev_sclk === 1'b1) begin
            fall_cnt++;
            if (cs_n === 1'b0 && miso_idx < 16) begin
                miso = miso_word[4'(15 - miso_idx)];
                miso_idx++;
            end
        end
        if (sclk !== prev_sclk && cs_n === 1'b1) cs_edges++;
        if (busy === 1'b1) busy_cyc++;
        if (cs_n === 1'b0) cs_low_cyc++;
        if (data_out_16bit !== prev_dout && cs_n === 1'b0) dout_moves++;
        if (cs_n === 1'b1) miso_idx = 0;
        prev_sclk = sclk;
        prev_dout = data_out_16bit;
    end

    int b_rise, b_fall, b_busy, b_cslow, b_edges, b_moves;

    task automatic snap();
        b_rise  = rise_cnt;
        b_fall  = fall_cnt;
        b_busy  = busy_cyc;
        b_cslow = cs_low_cyc;
        b_edges = cs_edges;
        b_moves = dout_moves;
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < int'(Budget); i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(negedge clk);
    endtask

    // One-cycle start pulse; data_in is scrambled right after acceptance.
    task automatic send(input logic [15:0] d, input logic [15:0] m);
        @(negedge clk);
        miso_word     = m;
        data_in_16bit = d;
        snap();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data_in_16bit = 16'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'($urandom);
        data_in_16bit = 16'($urandom);
        repeat (3) @(negedge clk);
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b expected 1", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (data_out_16bit !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", data_out_16bit); end
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        bit to;
        send(16'h2D08, 16'h0000);
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL write_timeout: busy stuck high"); end
        checks++; if (mosi_cap !== 16'h2D08) begin errors++; $display("FAIL write_mosi: got %h expected 2d08", mosi_cap); end
        checks++; if (rise_cnt - b_rise != 16) begin errors++; $display("FAIL write_rises: got %0d expected 16", rise_cnt - b_rise); end
        checks++; if (fall_cnt - b_fall != 16) begin errors++; $display("FAIL write_falls: got %0d expected 16", fall_cnt - b_fall); end
        checks++; if (busy_cyc - b_busy != int'(BusyLen)) begin errors++; $display("FAIL write_busy_len: got %0d expected %0d", busy_cyc - b_busy, BusyLen); end
        checks++; if (cs_low_cyc - b_cslow != int'(CsLowLen)) begin errors++; $display("FAIL write_cs_len: got %0d expected %0d", cs_low_cyc - b_cslow, CsLowLen); end
        checks++; if (data_out_16bit !== 16'h0000) begin errors++; $display("FAIL write_dout: got %h expected 0000", data_out_16bit); end
        checks++; if (cs_edges != b_edges) begin errors++; $display("FAIL write_cs_edges: got %0d expected 0", cs_edges - b_edges); end
    endtask

    task automatic test_read();
        bit to;
        send(16'hB200, 16'hFF5A);
        // Result must already be in place in the cycle busy drops.
        for (int i = 0; i < int'(Budget); i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        checks++; if (data_out_16bit !== 16'hFF5A) begin errors++; $display("FAIL read_dout_at_busy_fall: got %h expected ff5a", data_out_16bit); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL read_timeout: busy stuck high"); end
        checks++; if (mosi_cap !== 16'hB200) begin errors++; $display("FAIL read_mosi: got %h expected b200", mosi_cap); end
        checks++; if (dout_moves != b_moves) begin errors++; $display("FAIL read_dout_midframe: got %0d changes expected 0", dout_moves - b_moves); end
    endtask

    task automatic test_random();
        bit to;
        logic [15:0] d, m;
        for (int n = 0; n < 4; n++) begin
            d = 16'($urandom);
            m = 16'($urandom);
            send(d, m);
            wait_idle(to);
            checks++; if (to) begin errors++; $display("FAIL rand_timeout: frame %0d", n); end
            checks++; if (mosi_cap !== d) begin errors++; $display("FAIL rand_mosi: got %h expected %h", mosi_cap, d); end
            checks++; if (data_out_16bit !== m) begin errors++; $display("FAIL rand_dout: got %h expected %h", data_out_16bit, m); end
            checks++; if (rise_cnt - b_rise != 16) begin errors++; $display("FAIL rand_rises: got %0d expected 16", rise_cnt - b_rise); end
            repeat ($urandom_range(3, 30)) @(negedge clk);
            checks++; if (data_out_16bit !== m) begin errors++; $display("FAIL rand_dout_retain: got %h expected %h", data_out_16bit, m); end
        end
    endtask

    task automatic test_busy_ignore();
        bit to;
        send(16'h0A5F, 16'h1357);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (194) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(to);
        repeat (20) @(negedge clk);
        checks++; if (to) begin errors++; $display("FAIL ignore_timeout: busy stuck high"); end
        checks++; if (fall_cnt - b_fall != 16) begin errors++; $display("FAIL ignore_falls: got %0d expected 16", fall_cnt - b_fall); end
        checks++; if (busy_cyc - b_busy != int'(BusyLen)) begin errors++; $display("FAIL ignore_busy_len: got %0d expected %0d", busy_cyc - b_busy, BusyLen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        bit to;
        int gap_total = 0, gap_busy = 0, w = 0;
        logic [15:0] dout_gap;
        @(negedge clk);
        data_in_16bit = 16'h3C5A;
        miso_word = 16'h6A95;
        snap();
        start = 1'b1;
        // Skip to the end of frame 1.
        while (cs_n !== 1'b0 && w < int'(Budget)) begin @(negedge clk); w++; end
        while (cs_n !== 1'b1 && w < int'(Budget)) begin @(negedge clk); w++; end
        dout_gap = data_out_16bit;
        // cs_n high: CS_GAP cycles still busy plus the one IDLE cycle that re-accepts.
        while (cs_n === 1'b1 && w < int'(Budget)) begin
            gap_total++;
            if (busy === 1'b1) gap_busy++;
            @(negedge clk);
            w++;
        end
        start = 1'b0;
        miso_word = 16'hC3E1;
        checks++; if (w >= int'(Budget)) begin errors++; $display("FAIL b2b_timeout: waited %0d cycles", w); end
        checks++; if (dout_gap !== 16'h6A95) begin errors++; $display("FAIL b2b_dout1: got %h expected 6a95", dout_gap); end
        checks++; if (gap_busy != int'(CsGap)) begin errors++; $display("FAIL b2b_gap_busy: got %0d expected %0d", gap_busy, CsGap); end
        checks++; if (gap_total != int'(CsGap) + 1) begin errors++; $display("FAIL b2b_gap_total: got %0d expected %0d", gap_total, CsGap + 1); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout2: busy stuck high"); end
        checks++; if (data_out_16bit !== 16'hC3E1) begin errors++; $display("FAIL b2b_dout2: got %h expected c3e1", data_out_16bit); end
        checks++; if (mosi_cap !== 16'h3C5A) begin errors++; $display("FAIL b2b_mosi2: got %h expected 3c5a", mosi_cap); end
        checks++; if (fall_cnt - b_fall != 32) begin errors++; $display("FAIL b2b_falls: got %0d expected 32", fall_cnt - b_fall); end
        checks++; if (cs_edges != b_edges) begin errors++; $display("FAIL b2b_cs_edges: got %0d expected 0", cs_edges - b_edges); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int w = 0;
        send(16'hB200, 16'h1234);
        while (rise_cnt - b_rise < 7 && w < int'(Budget)) begin @(negedge clk); w++; end
        checks++; if (w >= int'(Budget)) begin errors++; $display("FAIL midrst_timeout: 7th rise not seen"); end
        reset_n = 1'b0;
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL midrst_cs_n: got %b expected 1", cs_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (data_out_16bit !== 16'h0000) begin errors++; $display("FAIL midrst_dout: got %h expected 0000", data_out_16bit); end
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL midrst_sclk: got %b expected 1", sclk); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        send(16'hB200, 16'h0011);
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL midrst_timeout2: busy stuck high"); end
        checks++; if (data_out_16bit !== 16'h0011) begin errors++; $display("FAIL midrst_dout2: got %h expected 0011", data_out_16bit); end
        checks++; if (mosi_cap !== 16'hB200) begin errors++; $display("FAIL midrst_mosi2: got %h expected b200", mosi_cap); end
        checks++; if (rise_cnt - b_rise != 16) begin errors++; $display("FAIL midrst_rises: got %0d expected 16", rise_cnt - b_rise); end
        checks++; if (busy_cyc - b_busy != int'(BusyLen)) begin errors++; $display("FAIL midrst_busy_len: got %0d expected %0d", busy_cyc - b_busy, BusyLen); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
